alu_multicycle: RTL
===================

Name: alu_multicycle

Overview:
Parametrised successor to the datapath's single-cycle ALU. Adds a valid/ready handshake, a configurable operand width, and iterative unsigned multiply/divide. Accepts one operation at a time and holds the result until the consumer takes it. Sits between the decode/register-read stage and writeback, and lets the core stall on long operations.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 4..64.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and op are valid this cycle
in_ready  output  1  block can accept an operation
op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed), 101 MULU (low WIDTH bits), 110 DIVU quotient, 111 REMU remainder
in1  input  WIDTH  operand A (dividend / multiplicand)
in2  input  WIDTH  operand B (divisor / multiplier)
out_valid  output  1  result valid; held until accepted
out_ready  input  1  consumer accepts result
out  output  WIDTH  result
zero  output  1  out == 0, qualified by out_valid
div_by_zero  output  1  DIVU/REMU issued with in2 == 0; valid with out_valid

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out=0, zero=0 (computed only while out_valid=1), div_by_zero=0, counter=0. Reset asserted mid-operation aborts the operation; no result is produced.
- States:
  - IDLE: in_ready=1.
  - CALC: in_ready=0, iterating.
  - DONE: in_ready=0, out_valid=1.
- Transitions:
  - Accept occurs when in_valid & in_ready. In1, in2 and op are latched; the inputs are ignored afterwards.
  - Single-cycle ops (ADD, SUB, AND, OR, SLT): IDLE -> DONE. Result registered on the accept edge, so out_valid rises the cycle after accept (latency 1).
  - MULU/DIVU/REMU: IDLE -> CALC. Counter loads WIDTH; one bit is processed per cycle. When the counter reaches 0 after the last step, go to DONE. out_valid rises WIDTH+1 cycles after accept.
  - DONE: while out_ready=0, hold out, zero and div_by_zero stable. Transfer happens when out_valid & out_ready; then go to IDLE.
  - No accept is allowed in the cycle of transfer: in_ready=1 only in IDLE, so throughput is at most one op per 2 cycles.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT: out = 1 if $signed(in1) < $signed(in2), else 0; zero-extended.
  - MULU: shift-add over WIDTH iterations. Only the low WIDTH bits are returned; the upper half is discarded.
  - DIVU/REMU: restoring division, WIDTH iterations. The remainder register is WIDTH+1 bits.
  - Divide by zero: skip iteration and go IDLE -> DONE at latency 1. DIVU returns all ones; REMU returns in1; div_by_zero=1.
- Boundaries:
  - in_valid asserted while busy: ignored; the source must hold it until in_ready.
  - op change during CALC: no effect.
  - WIDTH-1 shift of the all-ones operand: handled by the counter, with no extra cycle.

Test Plan:
- Reset mid-MULU (rst_n low at cycle 5 of 32) -> out_valid=0 and in_ready=1 immediately; a subsequent ADD 3+4 returns 7 one cycle after accept.
- WIDTH=32: ADD 0xFFFFFFFF+1 -> out=0, zero=1. SUB 5-7 -> 0xFFFFFFFE. SLT -1,1 -> 1. SLT 1,-1 -> 0.
- WIDTH=32: MULU 0x10000*0x10000 -> out=0, zero=1, out_valid exactly 33 cycles after accept. MULU 1234*5678 -> 7006652.
- WIDTH=32: DIVU 100/7 -> 14, REMU 100/7 -> 2, each at latency 33. DIVU 5/0 -> 0xFFFFFFFF, div_by_zero=1, latency 1. REMU 5/0 -> 5.
- Back-pressure: hold out_ready=0 for 10 cycles after an AND 0xF0&0x3C result -> out stays 0x30, in_ready stays 0, and a new in_valid is ignored. Release -> transfer, then in_ready=1 next cycle.
- WIDTH=8 instance: MULU 16*16 -> 0; DIVU 255/16 -> 15 at latency 9; random sweep against a reference model for all ops.

Source files
------------

// File: rtl/alu_multicycle_if.sv
// ---------------------------------------------------------------------------
// alu_multicycle_if
// Handshake bundle between an operation source (decode/register read) and the
// multicycle ALU, plus the result path towards writeback.
//   in_valid/in_ready    : operation handshake, op/in1/in2 qualified by in_valid
//   out_valid/out_ready  : result handshake, out/zero/div_by_zero held in DONE
// Modports: master = operation source / result consumer, slave = ALU.
// ---------------------------------------------------------------------------
interface alu_multicycle_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             zero;
   logic             div_by_zero;

   modport master (
      output in_valid, op, in1, in2, out_ready,
      input  in_ready, out_valid, out, zero, div_by_zero
   );

   modport slave (
      input  in_valid, op, in1, in2, out_ready,
      output in_ready, out_valid, out, zero, div_by_zero
   );
endinterface

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
// Handshaked ALU: ADD/SUB/AND/OR/SLT complete in one cycle, MULU/DIVU/REMU
// iterate one bit per cycle (shift-add multiply, restoring divide). One
// operation in flight; the result is held until the consumer accepts it.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_multicycle_if.slave (operation and result handshakes)
// ---------------------------------------------------------------------------
module alu_multicycle #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_multicycle_if.slave    bus
);
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_SLT  = 3'b100;
   localparam logic [2:0] OP_MULU = 3'b101;
   localparam logic [2:0] OP_DIVU = 3'b110;
   localparam logic [2:0] OP_REMU = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_zero;
   logic             r_dbz;
   logic [WIDTH-1:0] r_out;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_op;
   // MULU: r_opa = shifting multiplicand, r_opb = shifting multiplier.
   // DIVU/REMU: r_opa = divisor, r_opb = dividend bits shifting out while
   // quotient bits shift in from the bottom.
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH:0]   r_rem;

   logic             w_accept;
   logic             w_is_iter;
   logic             w_div_zero;
   logic [WIDTH-1:0] w_single;
   logic [WIDTH-1:0] w_acc_next;
   logic [WIDTH:0]   w_trial;
   logic             w_ge;
   logic [WIDTH:0]   w_rem_next;
   logic [WIDTH-1:0] w_quo_next;
   logic [WIDTH-1:0] w_calc_res;

   assign w_accept   = bus.in_valid & r_in_ready;
   assign w_is_iter  = (bus.op == OP_MULU) || (bus.op == OP_DIVU) || (bus.op == OP_REMU);
   assign w_div_zero = (bus.op[2:1] == 2'b11) && (bus.in2 == '0);

   // Result for everything that finishes on the accept edge, including the
   // divide-by-zero shortcut.
   always_comb begin
      w_single = '0;
      case (bus.op)
         OP_ADD:  w_single = bus.in1 + bus.in2;
         OP_SUB:  w_single = bus.in1 - bus.in2;
         OP_AND:  w_single = bus.in1 & bus.in2;
         OP_OR:   w_single = bus.in1 | bus.in2;
         OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
         OP_DIVU: w_single = '1;
         OP_REMU: w_single = bus.in1;
         default: w_single = '0;
      endcase
   end

   // One iteration step for each of the long operations.
   assign w_acc_next = r_opb[0] ? (r_acc + r_opa) : r_acc;
   assign w_trial    = {r_rem[WIDTH-1:0], r_opb[WIDTH-1]};
   assign w_ge       = (w_trial >= {1'b0, r_opa});
   assign w_rem_next = w_ge ? (w_trial - {1'b0, r_opa}) : w_trial;
   assign w_quo_next = {r_opb[WIDTH-2:0], w_ge};

   always_comb begin
      w_calc_res = w_rem_next[WIDTH-1:0];
      if (r_op == OP_MULU)
         w_calc_res = w_acc_next;
      else if (r_op == OP_DIVU)
         w_calc_res = w_quo_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_zero      <= 1'b0;
         r_dbz       <= 1'b0;
         r_out       <= '0;
         r_cnt       <= '0;
         r_op        <= OP_ADD;
         r_opa       <= '0;
         r_opb       <= '0;
         r_acc       <= '0;
         r_rem       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op       <= bus.op;
                  r_in_ready <= 1'b0;
                  if (w_is_iter && !w_div_zero) begin
                     r_state <= S_CALC;
                     r_cnt   <= CNT_W'(WIDTH);
                     r_opa   <= (bus.op == OP_MULU) ? bus.in1 : bus.in2;
                     r_opb   <= (bus.op == OP_MULU) ? bus.in2 : bus.in1;
                     r_acc   <= '0;
                     r_rem   <= '0;
                  end else begin
                     r_state     <= S_DONE;
                     r_out       <= w_single;
                     r_zero      <= (w_single == '0);
                     r_dbz       <= w_div_zero;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt - 1'b1;
               if (r_op == OP_MULU) begin
                  r_acc <= w_acc_next;
                  r_opa <= r_opa << 1;
                  r_opb <= r_opb >> 1;
               end else begin
                  r_rem <= w_rem_next;
                  r_opb <= w_quo_next;
               end
               // Last step writes the result directly so DONE follows with no
               // extra cycle.
               if (r_cnt == CNT_W'(1)) begin
                  r_state     <= S_DONE;
                  r_out       <= w_calc_res;
                  r_zero      <= (w_calc_res == '0);
                  r_dbz       <= 1'b0;
                  r_out_valid <= 1'b1;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_zero      <= 1'b0;
                  r_dbz       <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready    = r_in_ready;
   assign bus.out_valid   = r_out_valid;
   assign bus.out         = r_out;
   assign bus.zero        = r_zero;
   assign bus.div_by_zero = r_dbz;
endmodule
